kb_event_decoder: RTL and testbench
===================================

Name: kb_event_decoder

Overview:
Parametrised PS/2 set-2 scan-byte decoder. It turns the byte stream from the team's ps2_rx receiver into complete key events: make or break, standard or extended (E0), and the Pause sequence (E1). It filters typematic repeats and buffers events in an internal first-word-fall-through FIFO for a consumer such as a UART or an ASCII translator. It supersedes the make-only code holder and sits between ps2_rx and the application logic.

Parameters:
FIFO_W, 2, log2 of the event FIFO depth (2^FIFO_W words).
REPORT_BREAK, 1, 1 = release events are queued; 0 = break sequences are consumed silently.
FILTER_REPEAT, 1, 1 = a make code equal to the currently held key is dropped; 0 = every make is queued.
TIMEOUT_CYCLES, 100000, clock cycles allowed between bytes of one sequence (used only with KB_EVT_TIMEOUT_EN).

Ports:
i_clk  in  1  system clock; every register is rising-edge triggered.
i_reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of i_clk.
i_scan_data  in  8  scan byte from ps2_rx; valid only while i_scan_done_tick is 1.
i_scan_done_tick  in  1  one-cycle strobe, one per received byte.
i_rd  in  1  pops the head event; ignored while o_empty = 1.
i_clr_ovf  in  1  clears o_overflow.
o_evt  out  10  head event {brk, ext, code[7:0]}; shown at the FIFO head (FWFT).
o_empty  out  1  FIFO empty.
o_full  out  1  FIFO full.
o_overflow  out  1  sticky flag: an event was dropped because the FIFO was full.
o_err_tick  out  1  one-cycle pulse on a keyboard error byte (00 or FF).

Behaviour:
- Reset (i_reset_n = 0 at a clock edge) gives: state IDLE; FIFO empty with pointers at 0; o_evt = 0; o_empty = 1; o_full = 0; o_overflow = 0; o_err_tick = 0; held-key register invalid; skip counter = 0. Reset in the middle of a sequence discards the partial sequence.
- Bytes are processed only on cycles where i_scan_done_tick = 1. All other inputs are sampled every cycle.
- States and transitions:
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - E1 -> queue {0,1,E1}, load the skip counter with 7, go to SKIP.
    - 00 or FF -> pulse o_err_tick, stay in IDLE.
    - AA, FA, FE -> drop, stay in IDLE.
    - Any other byte -> make event {0,0,b}.
  - EXT:
    - F0 -> EXT_BRK.
    - 12 or 59 (fake shift) -> drop, go to IDLE.
    - Any other byte -> make event {0,1,b}, go to IDLE.
  - BRK: next byte -> break event {1,0,b}, go to IDLE.
  - EXT_BRK:
    - 12 or 59 -> drop, go to IDLE.
    - Any other byte -> break event {1,1,b}, go to IDLE.
  - SKIP: each byte decrements the counter; when it reaches 0, go to IDLE. The Pause key produces exactly one event.
- Make-event handling:
  - FILTER_REPEAT = 1 and held-key valid with held {ext,code} equal to the new {ext,code} -> drop the event.
  - Otherwise queue it and load the held-key register with {ext,code}, valid = 1.
- Break-event handling:
  - If {ext,code} matches the held key, clear held-key valid.
  - Queue the event only when REPORT_BREAK = 1.
- The push happens in the same cycle as the completing i_scan_done_tick. The event appears on o_evt and o_empty falls on the following cycle, giving a 1-cycle latency from strobe to visible event.
- FIFO push/pop rules:
  - Push while full with no pop: the event is dropped and o_overflow is set. If i_clr_ovf = 1 in the same cycle, the set wins.
  - Push and pop in the same cycle while full: both succeed; the FIFO stays full.
  - Push and pop in the same cycle while empty: the pop is ignored and the push succeeds.
- o_full and o_empty are registered. Pointers are FIFO_W bits wide and wrap modulo 2^FIFO_W.

Optional Feature:
KB_EVT_TIMEOUT_EN
- Defined: a cycle counter clears on every i_scan_done_tick and counts while the state is not IDLE. Reaching TIMEOUT_CYCLES-1 returns the state to IDLE, discards the partial sequence, and pulses o_err_tick for one cycle. The FIFO and held-key register are unaffected.
- Undefined: there is no counter, and the decoder waits indefinitely in EXT, BRK, EXT_BRK or SKIP.

Test Plan:
- Bytes 1C, F0, 1C with defaults -> events {0,0,1C} then {1,0,1C}; o_empty falls 1 cycle after the first strobe.
- Bytes E0 75, E0 F0 75 -> events {0,1,75} then {1,1,75}. Bytes E0 12 E0 7C -> only {0,1,7C} is queued.
- Bytes 1C, 1C, 1C, F0, 1C with FILTER_REPEAT = 1 -> exactly 2 events. With FILTER_REPEAT = 0 -> 4 events. With REPORT_BREAK = 0 -> only the make events.
- Pause sequence E1 14 77 E1 F0 14 F0 77 followed by 1C -> events {0,1,E1} then {0,0,1C}.
- FIFO_W = 2, six distinct makes with no reads -> o_full = 1, o_overflow = 1, and the 4 oldest events are read back in order. i_clr_ovf then clears the flag. A simultaneous push and pop while full keeps the count at 4.
- i_reset_n low for one cycle after E0 -> state returns to IDLE; a following 1C gives {0,0,1C}. With KB_EVT_TIMEOUT_EN: E0 followed by TIMEOUT_CYCLES idle cycles pulses o_err_tick, and a following 1C gives {0,0,1C}.

Source files
------------

// File: rtl/kb_event_decoder.sv
`default_nettype none
//============================================================================
// Module   : kb_event_decoder
// Purpose  : PS/2 set-2 scan-byte decoder. Assembles the raw byte stream
//            from ps2_rx into complete key events (make/break, standard or
//            E0-extended, E1 Pause), filters typematic repeats and queues
//            the events in a first-word-fall-through FIFO.
// Ports    : i_clk            system clock, rising edge
//            i_reset_n        synchronous active-low reset
//            i_scan_data      scan byte, valid while i_scan_done_tick = 1
//            i_scan_done_tick one-cycle strobe per received byte
//            i_rd             pop the head event (ignored when empty)
//            i_clr_ovf        clear the sticky overflow flag
//            o_evt            head event {brk, ext, code[7:0]}
//            o_empty/o_full   registered FIFO status
//            o_overflow       sticky: an event was dropped on a full FIFO
//            o_err_tick       one-cycle pulse on keyboard error (00/FF)
// Options  : `define KB_EVT_TIMEOUT_EN to abandon a partial sequence after
//            TIMEOUT_CYCLES cycles without a byte (also pulses o_err_tick).
// Revision : 1.0 - initial release
//============================================================================
module kb_event_decoder #(
    parameter int FIFO_W         = 2,
    parameter int REPORT_BREAK   = 1,
    parameter int FILTER_REPEAT  = 1,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [7:0] i_scan_data,
    input  logic       i_scan_done_tick,
    input  logic       i_rd,
    input  logic       i_clr_ovf,
    output logic [9:0] o_evt,
    output logic       o_empty,
    output logic       o_full,
    output logic       o_overflow,
    output logic       o_err_tick
);

    localparam int              c_DEPTH_INT = 2 ** FIFO_W;
    localparam logic [FIFO_W:0] c_DEPTH     = (FIFO_W + 1)'(c_DEPTH_INT);
    localparam bit              c_FILTER    = (FILTER_REPEAT != 0);
    localparam bit              c_REPORT    = (REPORT_BREAK != 0);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXT     = 3'd1,
        S_BRK     = 3'd2,
        S_EXT_BRK = 3'd3,
        S_SKIP    = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_skip_cnt;
    logic [2:0]        w_skip_nxt;
    logic [2:0]        w_skip_dec;
    logic              r_held_valid;
    logic [8:0]        r_held_key;
    logic              r_err_tick;
    logic              r_overflow;

    logic              w_err_byte;
    logic              w_make;
    logic              w_brk;
    logic              w_ext;
    logic              w_pause;
    logic              w_timeout;
    logic [8:0]        w_key;
    logic              w_match;
    logic              w_push;
    logic [9:0]        w_push_data;
    logic              w_held_load;
    logic              w_held_clr;

    logic [9:0]        r_mem [c_DEPTH_INT];
    logic [FIFO_W-1:0] r_wr_ptr;
    logic [FIFO_W-1:0] r_rd_ptr;
    logic [FIFO_W:0]   r_count;
    logic [FIFO_W:0]   w_count_nxt;
    logic              r_empty;
    logic              r_full;
    logic              w_do_pop;
    logic              w_do_push;
    logic              w_ovf_set;

    //------------------------------------------------------------------------
    // Inter-byte timeout (optional)
    //------------------------------------------------------------------------
`ifdef KB_EVT_TIMEOUT_EN
    localparam int unsigned       c_TO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

    logic [c_TO_W-1:0] r_to_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_to_cnt <= '0;
        end else if (i_scan_done_tick || (r_state == S_IDLE) || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // A strobe on the same cycle always takes priority over the timeout.
    assign w_timeout = (r_state != S_IDLE) && !i_scan_done_tick && (r_to_cnt == c_TO_LAST);
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign w_timeout            = 1'b0;
`endif

    //------------------------------------------------------------------------
    // Sequence decoder: next state and the completed event, if any
    //------------------------------------------------------------------------
    assign w_skip_dec = r_skip_cnt - 3'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_skip_nxt  = r_skip_cnt;
        w_err_byte  = 1'b0;
        w_make      = 1'b0;
        w_brk       = 1'b0;
        w_ext       = 1'b0;
        w_pause     = 1'b0;

        if (i_scan_done_tick) begin
            case (r_state)
                S_IDLE: begin
                    case (i_scan_data)
                        8'hE0: w_state_nxt = S_EXT;
                        8'hF0: w_state_nxt = S_BRK;
                        8'hE1: begin
                            // Pause is reported once; its remaining 7 bytes are swallowed.
                            w_pause     = 1'b1;
                            w_skip_nxt  = 3'd7;
                            w_state_nxt = S_SKIP;
                        end
                        8'h00, 8'hFF: w_err_byte = 1'b1;
                        8'hAA, 8'hFA, 8'hFE: ;  // BAT pass / ACK / resend: not keys
                        default: w_make = 1'b1;
                    endcase
                end
                S_EXT: begin
                    case (i_scan_data)
                        8'hF0: w_state_nxt = S_EXT_BRK;
                        8'h12, 8'h59: w_state_nxt = S_IDLE;  // fake shift
                        default: begin
                            w_make      = 1'b1;
                            w_ext       = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    endcase
                end
                S_BRK: begin
                    w_brk       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                S_EXT_BRK: begin
                    w_state_nxt = S_IDLE;
                    if ((i_scan_data != 8'h12) && (i_scan_data != 8'h59)) begin
                        w_brk = 1'b1;
                        w_ext = 1'b1;
                    end
                end
                S_SKIP: begin
                    w_skip_nxt = w_skip_dec;
                    if (w_skip_dec == 3'd0) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        if (w_timeout) begin
            w_state_nxt = S_IDLE;
            w_skip_nxt  = 3'd0;
        end
    end

    //------------------------------------------------------------------------
    // Event filtering against the held key
    //------------------------------------------------------------------------
    assign w_key   = {w_ext, i_scan_data};
    assign w_match = r_held_valid && (r_held_key == w_key);

    always_comb begin
        w_push      = 1'b0;
        w_push_data = '0;
        w_held_load = 1'b0;
        w_held_clr  = 1'b0;

        if (w_pause) begin
            w_push      = 1'b1;
            w_push_data = {1'b0, 1'b1, 8'hE1};
        end else if (w_make) begin
            if (!(c_FILTER && w_match)) begin
                w_push      = 1'b1;
                w_push_data = {1'b0, w_key};
                w_held_load = 1'b1;
            end
        end else if (w_brk) begin
            w_held_clr  = w_match;
            w_push      = c_REPORT;
            w_push_data = {1'b1, w_key};
        end
    end

    //------------------------------------------------------------------------
    // FWFT FIFO
    //------------------------------------------------------------------------
    assign w_do_pop  = i_rd && !r_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_do_push = w_push && (!r_full || w_do_pop);
    assign w_ovf_set = w_push && r_full && !w_do_pop;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state      <= S_IDLE;
            r_skip_cnt   <= 3'd0;
            r_held_valid <= 1'b0;
            r_held_key   <= '0;
            r_err_tick   <= 1'b0;
            r_overflow   <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_empty      <= 1'b1;
            r_full       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_skip_cnt <= w_skip_nxt;
            r_err_tick <= w_err_byte || w_timeout;

            if (w_held_load) begin
                r_held_valid <= 1'b1;
                r_held_key   <= w_key;
            end else if (w_held_clr) begin
                r_held_valid <= 1'b0;
            end

            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (i_clr_ovf) begin
                r_overflow <= 1'b0;
            end

            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == c_DEPTH);
        end
    end

    assign o_evt      = r_empty ? 10'd0 : r_mem[r_rd_ptr];
    assign o_empty    = r_empty;
    assign o_full     = r_full;
    assign o_overflow = r_overflow;
    assign o_err_tick = r_err_tick;

endmodule
`default_nettype wire

// File: tb/tb_kb_event_decoder.sv
`default_nettype none
//============================================================================
// Module   : tb_kb_event_decoder
// Purpose  : Self-checking bench for kb_event_decoder. Three instances
//            share one scan-byte stream: defaults (d0), FILTER_REPEAT = 0
//            (d1) and REPORT_BREAK = 0 (d2). A sequence-level model of the
//            decoder and a list model of the FIFO are compared with every
//            DUT output each cycle; directed literals pin the model.
// Options  : KB_EVT_TIMEOUT_EN enables the timeout scenario and model.
// Revision : 1.0 - initial release
//============================================================================
module tb_kb_event_decoder;

    localparam int c_TO = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] scan_data;
    logic       tick;
    logic       clr_ovf;
    logic       rd    [3];
    logic [9:0] evt   [3];
    logic       empty [3];
    logic       full  [3];
    logic       ovf   [3];
    logic       err   [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    kb_event_decoder #(.FIFO_W(2), .REPORT_BREAK(1), .FILTER_REPEAT(1), .TIMEOUT_CYCLES(c_TO)) u_d0 (
        .i_clk(clk), .i_reset_n(reset_n), .i_scan_data(scan_data), .i_scan_done_tick(tick),
        .i_rd(rd[0]), .i_clr_ovf(clr_ovf), .o_evt(evt[0]), .o_empty(empty[0]),
        .o_full(full[0]), .o_overflow(ovf[0]), .o_err_tick(err[0]));

    kb_event_decoder #(.FIFO_W(2), .REPORT_BREAK(1), .FILTER_REPEAT(0), .TIMEOUT_CYCLES(c_TO)) u_d1 (
        .i_clk(clk), .i_reset_n(reset_n), .i_scan_data(scan_data), .i_scan_done_tick(tick),
        .i_rd(rd[1]), .i_clr_ovf(clr_ovf), .o_evt(evt[1]), .o_empty(empty[1]),
        .o_full(full[1]), .o_overflow(ovf[1]), .o_err_tick(err[1]));

    kb_event_decoder #(.FIFO_W(2), .REPORT_BREAK(0), .FILTER_REPEAT(1), .TIMEOUT_CYCLES(c_TO)) u_d2 (
        .i_clk(clk), .i_reset_n(reset_n), .i_scan_data(scan_data), .i_scan_done_tick(tick),
        .i_rd(rd[2]), .i_clr_ovf(clr_ovf), .o_evt(evt[2]), .o_empty(empty[2]),
        .o_full(full[2]), .o_overflow(ovf[2]), .o_err_tick(err[2]));

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d at %0t: got 0x%0h, required 0x%0h", nm, d, $time, act, exp);
        end
    endtask

    //------------------------------------------------------------------------
    // Model: byte sequence buffer + event list per instance
    //------------------------------------------------------------------------
    logic [9:0] mf    [3][4];
    int         mn    [3];
    bit         mov   [3];
    bit         merr  [3];
    bit         setov [3];
    bit         hv    [3];
    logic [8:0] hk    [3];
    logic [7:0] sq    [3][8];
    int         sl    [3];
    int         idle  [3];
    bit         mvalid = 1'b0;

    function automatic bit filt_en(input int d);
        return d != 1;
    endfunction

    function automatic bit rep_en(input int d);
        return d != 2;
    endfunction

    task automatic mpush(input int d, input logic [9:0] e);
        if (mn[d] < 4) begin
            mf[d][mn[d]] = e;
            mn[d]++;
        end else begin
            setov[d] = 1'b1;
        end
    endtask

    task automatic mbyte(input int d, input logic [7:0] b);
        bit         ext;
        bit         brk;
        logic [7:0] code;
        logic [8:0] key;
        ext  = 1'b0;
        brk  = 1'b0;
        if (sl[d] == 0) begin
            if (b == 8'h00 || b == 8'hFF) begin
                merr[d] = 1'b1;
                return;
            end
            if (b == 8'hAA || b == 8'hFA || b == 8'hFE) return;
        end
        sq[d][sl[d]] = b;
        sl[d]++;
        if (sq[d][0] == 8'hE1) begin
            if (sl[d] == 1) mpush(d, 10'h1E1);
            if (sl[d] == 8) sl[d] = 0;
            return;
        end
        if (sq[d][0] == 8'hE0) begin
            if (sl[d] == 1) return;
            if (sq[d][1] == 8'hF0) begin
                if (sl[d] == 2) return;
                brk  = 1'b1;
                code = sq[d][2];
            end else begin
                code = sq[d][1];
            end
            ext = 1'b1;
        end else if (sq[d][0] == 8'hF0) begin
            if (sl[d] == 1) return;
            brk  = 1'b1;
            code = sq[d][1];
        end else begin
            code = sq[d][0];
        end
        sl[d] = 0;
        if (ext && (code == 8'h12 || code == 8'h59)) return;
        key = {ext, code};
        if (!brk) begin
            if (filt_en(d) && hv[d] && hk[d] == key) return;
            mpush(d, {1'b0, key});
            hv[d] = 1'b1;
            hk[d] = key;
        end else begin
            if (hv[d] && hk[d] == key) hv[d] = 1'b0;
            if (rep_en(d)) mpush(d, {1'b1, key});
        end
    endtask

    task automatic mstep();
        if (!reset_n) begin
            for (int d = 0; d < 3; d++) begin
                mn[d] = 0; mov[d] = 0; merr[d] = 0; hv[d] = 0; sl[d] = 0; idle[d] = 0;
            end
            mvalid = 1'b1;
            return;
        end
        for (int d = 0; d < 3; d++) begin
            setov[d] = 1'b0;
            merr[d]  = 1'b0;
            if (rd[d] && mn[d] > 0) begin
                for (int i = 0; i < 3; i++) mf[d][i] = mf[d][i+1];
                mn[d]--;
            end
            if (tick) begin
                idle[d] = 0;
                mbyte(d, scan_data);
            end else if (sl[d] > 0) begin
                idle[d]++;
`ifdef KB_EVT_TIMEOUT_EN
                if (idle[d] == c_TO) begin
                    sl[d]   = 0;
                    idle[d] = 0;
                    merr[d] = 1'b1;
                end
`endif
            end
            if (setov[d]) mov[d] = 1'b1;
            else if (clr_ovf) mov[d] = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        mstep();
        #1;
        if (mvalid) begin
            for (int d = 0; d < 3; d++) begin
                chk("evt",   d, 32'(evt[d]),   (mn[d] > 0) ? 32'(mf[d][0]) : 32'd0);
                chk("empty", d, 32'(empty[d]), 32'(mn[d] == 0));
                chk("full",  d, 32'(full[d]),  32'(mn[d] == 4));
                chk("ovf",   d, 32'(ovf[d]),   32'(mov[d]));
                chk("err",   d, 32'(err[d]),   32'(merr[d]));
            end
        end
    end

    //------------------------------------------------------------------------
    // Directed stimulus
    //------------------------------------------------------------------------
    int popped [3];

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        scan_data = b;
        tick      = 1'b1;
        @(negedge clk);
        tick      = 1'b0;
        scan_data = 8'h00;
    endtask

    // Pop one event from every non-empty instance; d0's head must match.
    task automatic pop_lit(input logic [9:0] exp);
        @(negedge clk);
        chk("lit_head", 0, 32'(evt[0]), 32'(exp));
        for (int d = 0; d < 3; d++) rd[d] = !empty[d];
        @(negedge clk);
        for (int d = 0; d < 3; d++) rd[d] = 1'b0;
    endtask

    task automatic drain();
        bit any;
        for (int d = 0; d < 3; d++) popped[d] = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            any = 1'b0;
            for (int d = 0; d < 3; d++) begin
                rd[d] = !empty[d];
                if (!empty[d]) begin
                    popped[d]++;
                    any = 1'b1;
                end
            end
            if (!any) break;
        end
        for (int d = 0; d < 3; d++) rd[d] = 1'b0;
    endtask

    initial begin
        int errcnt;
        reset_n   = 1'b0;
        scan_data = 8'h00;
        tick      = 1'b0;
        clr_ovf   = 1'b0;
        for (int d = 0; d < 3; d++) rd[d] = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_empty", 0, 32'(empty[0]), 32'd1);
        chk("rst_full",  0, 32'(full[0]),  32'd0);
        chk("rst_evt",   0, 32'(evt[0]),   32'd0);
        chk("rst_ovf",   0, 32'(ovf[0]),   32'd0);
        reset_n = 1'b1;

        // Error byte and ignored keyboard status byte
        send(8'hFF);
        chk("lit_err_pulse", 0, 32'(err[0]), 32'd1);
        send(8'hAA);
        chk("lit_aa_dropped", 0, 32'(empty[0]), 32'd1);

        // 1C, F0 1C with the 1-cycle strobe-to-event latency
        @(negedge clk);
        scan_data = 8'h1C;
        tick      = 1'b1;
        chk("lit_pre_empty", 0, 32'(empty[0]), 32'd1);
        @(negedge clk);
        tick = 1'b0;
        chk("lit_lat_empty", 0, 32'(empty[0]), 32'd0);
        chk("lit_lat_evt",   0, 32'(evt[0]),   32'h01C);
        send(8'hF0);
        send(8'h1C);
        pop_lit(10'h01C);
        pop_lit(10'h21C);
        drain();

        // Extended make/break, then fake shift
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        pop_lit(10'h175);
        pop_lit(10'h375);
        drain();
        send(8'hE0); send(8'h12);
        send(8'hE0); send(8'h7C);
        pop_lit(10'h17C);
        drain();
        chk("lit_fake_shift_count", 0, 32'(popped[0]), 32'd0);

        // Typematic repeats
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
        drain();
        chk("lit_repeat_filter", 0, 32'(popped[0]), 32'd2);
        chk("lit_repeat_nofilt", 1, 32'(popped[1]), 32'd4);
        chk("lit_repeat_nobrk",  2, 32'(popped[2]), 32'd1);

        // Pause sequence yields one event
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        send(8'h1C);
        pop_lit(10'h1E1);
        pop_lit(10'h01C);
        drain();
        chk("lit_pause_count", 0, 32'(popped[0]), 32'd0);

        // Overflow: six distinct makes into a 4-deep FIFO
        send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C); send(8'h35);
        chk("lit_ovf_full", 0, 32'(full[0]), 32'd1);
        chk("lit_ovf_flag", 0, 32'(ovf[0]),  32'd1);
        @(negedge clk);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        chk("lit_ovf_clr", 0, 32'(ovf[0]), 32'd0);
        // Simultaneous push and pop while full
        @(negedge clk);
        chk("lit_head", 0, 32'(evt[0]), 32'h015);
        scan_data = 8'h3C;
        tick      = 1'b1;
        for (int d = 0; d < 3; d++) rd[d] = !empty[d];
        @(negedge clk);
        tick = 1'b0;
        for (int d = 0; d < 3; d++) rd[d] = 1'b0;
        chk("lit_pushpop_full", 0, 32'(full[0]), 32'd1);
        chk("lit_pushpop_ovf",  0, 32'(ovf[0]),  32'd0);
        pop_lit(10'h01D);
        pop_lit(10'h024);
        pop_lit(10'h02D);
        pop_lit(10'h03C);
        drain();

        // Reset in the middle of an extended sequence
        send(8'hE0);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        send(8'h1C);
        pop_lit(10'h01C);
        drain();

`ifdef KB_EVT_TIMEOUT_EN
        // Release the held key, then abandon an E0 prefix by timeout
        send(8'hF0); send(8'h1C);
        drain();
        send(8'hE0);
        errcnt = 0;
        repeat (c_TO + 4) begin
            @(negedge clk);
            if (err[0]) errcnt++;
        end
        chk("lit_timeout_pulses", 0, 32'(errcnt), 32'd1);
        send(8'h1C);
        pop_lit(10'h01C);
        drain();
`else
        errcnt = 0;
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
